uart_rx_frame_ctrl: RTL
=======================

Name: uart_rx_frame_ctrl

Overview:
- Sequences the byte stream from the UART receiver into command frames: SYNC, CMD, ADDR, LEN, DATA[LEN], CKSUM.
- Detects each new byte from the receiver's done level, validates length and checksum, and enforces an inter-byte timeout.
- Buffers the payload, then drains it as address/data beats over a valid/ready interface to the register/bus side.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload bytes; buffer depth.
- TIMEOUT, 100000, clk cycles allowed between bytes inside a frame.
- TO_W, 17, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all inputs synchronous to it.
- rst  in  1  reset, synchronous, active-high.
- rx_done  in  1  receiver byte-done level; may stay high for many clk cycles per byte.
- rx_data  in  8  receiver byte; stable while rx_done high.
- out_valid  out  1  payload beat valid.
- out_ready  in  1  sink accepts beat.
- out_addr  out  8  ADDR + beat index, modulo 256.
- out_data  out  8  payload byte.
- out_cmd  out  8  CMD byte of the frame being drained.
- out_last  out  1  final beat of the frame.
- err_cksum  out  1  one-cycle pulse: checksum mismatch.
- err_len  out  1  one-cycle pulse: LEN==0 or LEN>MAX_LEN.
- err_timeout  out  1  one-cycle pulse: inter-byte timeout.
- overrun  out  1  one-cycle pulse: byte arrived during DRAIN and was dropped.
- busy  out  1  high in any state except HUNT.

Behaviour:
- Reset values:
  - state=HUNT.
  - out_valid, out_last, all err pulses, overrun, busy = 0.
  - out_addr, out_data, out_cmd = 0.
  - Checksum, index and timeout counters = 0.
  - done_prev = 1, so a done level already high at reset release is not taken as a byte.
- Byte strobe:
  - byte_stb = rx_done & ~done_prev; done_prev is registered every cycle.
  - rx_data is sampled in the byte_stb cycle.
  - A held done level yields exactly one strobe.
- State machine: HUNT, CMD, ADDR, LEN, DATA, CKSUM, DRAIN. Transitions take effect on the clk edge after byte_stb.
  - HUNT: on byte_stb, go to CMD if byte==SYNC_BYTE, else stay. Clear checksum.
  - CMD: store cmd, cksum=byte, go to ADDR.
  - ADDR: store addr, cksum+=byte, go to LEN.
  - LEN:
    - If byte==0 or byte>MAX_LEN: err_len pulse, go to HUNT.
    - Otherwise: store len, cksum+=byte, idx=0, go to DATA.
  - DATA: buf[idx]=byte, cksum+=byte, idx++. Go to CKSUM when idx reaches len.
  - CKSUM:
    - If byte==cksum (8-bit sum mod 256): idx=0, go to DRAIN.
    - Otherwise: err_cksum pulse, go to HUNT; payload discarded, no out_valid.
  - DRAIN:
    - out_valid=1, out_data=buf[idx], out_addr=addr+idx, out_cmd=cmd, out_last=(idx==len-1).
    - On out_valid&out_ready: idx++.
    - On the last handshake: go to HUNT, and out_valid drops in the next cycle.
    - Outputs are held stable while out_ready=0.
- Drain latency: first out_valid in the cycle after the CKSUM-state byte_stb edge, i.e. 1 cycle. With out_ready held high, one beat per cycle.
- Drain backpressure: any byte_stb in DRAIN is dropped with an overrun pulse. The byte is not parsed, and the state is unchanged.
- Timeout:
  - The counter runs in CMD..CKSUM, cleared on every byte_stb and on entering HUNT or DRAIN.
  - When the count reaches TIMEOUT with no strobe: err_timeout pulse, go to HUNT.
  - A byte_stb in the same cycle as the timeout wins: the byte is processed, no timeout.
  - The timeout counter is inactive in HUNT and DRAIN.
- Error pulses are mutually exclusive per cycle and are asserted in the cycle of the transition to HUNT.
- rst asserted mid-frame or mid-drain:
  - Return to HUNT next edge and drop out_valid.
  - Partial payload is discarded; no error pulse.
- Sequential SYNC handling: after any return to HUNT, the next SYNC_BYTE starts a frame. Payload bytes equal to SYNC_BYTE are data and carry no special meaning.

Test Plan:
- Good frame: A5,01,10,03,11,22,33 then cksum (01+10+03+11+22+33=0x7A), out_ready=1 -> 3 beats (10,11),(11,22),(12,33); out_cmd=01; out_last on beat 3; no errors.
- Bad checksum: same frame with cksum 7B -> err_cksum one pulse, out_valid never high, busy=0 next cycle.
- Length errors:
  - LEN=00 -> err_len, HUNT.
  - LEN=MAX_LEN+1 -> err_len.
  - LEN=MAX_LEN with correct cksum -> 16 beats, out_addr wrapping from FF to 00 when ADDR=F8.
- Timeout: A5,01 then idle TIMEOUT cycles -> err_timeout exactly once; a following full good frame is accepted normally.
- Backpressure:
  - Hold out_ready=0 for 50 cycles in DRAIN -> beats stable.
  - Inject a byte strobe during the hold -> overrun pulse, beats unaffected.
  - Release -> all beats delivered in order.
- Strobe and reset:
  - rx_done held high 200 cycles per byte, random lengths -> one byte per done level.
  - rst asserted during DATA -> HUNT, out_valid=0, no error pulse.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Turns the byte stream from a UART receiver into command frames:
//     SYNC, CMD, ADDR, LEN, DATA[LEN], CKSUM
//   The payload is buffered. It is released only after the checksum matches.
//   It then drains as address/data beats over a valid/ready interface.
//
// Ports
//   clk          system clock; all inputs are synchronous to it
//   rst          synchronous, active-high reset
//   rx_done      receiver byte-done level; may stay high for many cycles
//   rx_data      received byte; stable while rx_done is high
//   out_valid    payload beat valid
//   out_ready    sink accepts the beat
//   out_addr     ADDR + beat index, modulo 256
//   out_data     payload byte
//   out_cmd      CMD byte of the frame being drained
//   out_last     final beat of the frame
//   err_cksum    one-cycle pulse: checksum mismatch
//   err_len      one-cycle pulse: LEN == 0 or LEN > MAX_LEN
//   err_timeout  one-cycle pulse: inter-byte timeout inside a frame
//   overrun      one-cycle pulse: byte arrived during drain and was dropped
//   busy         high in every state except HUNT
//   dbg_state    current FSM state (debug visibility)
//
// Handshake: a beat transfers on a clk edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, all out_* stay stable.
// out_valid stays high until the beat is accepted.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int          MAX_LEN   = 16,
    parameter int          TIMEOUT   = 100000,
    parameter int          TO_W      = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_addr,
    output logic [7:0] out_data,
    output logic [7:0] out_cmd,
    output logic       out_last,
    output logic       err_cksum,
    output logic       err_len,
    output logic       err_timeout,
    output logic       overrun,
    output logic       busy,
    output logic [2:0] dbg_state
);
    localparam int IDX_W  = $clog2(MAX_LEN + 1);
    localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    // The timeout fires on the edge where the idle count would reach TIMEOUT.
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_HUNT, S_CMD, S_ADDR, S_LEN, S_DATA, S_CKSUM, S_DRAIN
    } state_t;

    state_t           state;
    logic             done_prev;
    logic             byte_stb;
    logic [7:0]       cmd_q;
    logic [7:0]       addr_q;
    logic [7:0]       cksum;
    logic [IDX_W-1:0] len_q;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
    logic [TO_W-1:0]  to_cnt;
    logic [7:0]       buf_mem [MAX_LEN];

    // done_prev resets to 1, so a done level already high at reset release
    // does not produce a strobe.
    assign byte_stb  = rx_done & ~done_prev;
    assign idx_inc   = idx + 1'b1;
    assign busy      = (state != S_HUNT);
    assign dbg_state = state;

    // Payload storage needs no reset.
    // Contents are only read after a full frame has written them.
    always_ff @(posedge clk) begin
        if (!rst && state == S_DATA && byte_stb)
            buf_mem[idx[BUF_AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_HUNT;
            done_prev   <= 1'b1;
            cmd_q       <= '0;
            addr_q      <= '0;
            cksum       <= '0;
            len_q       <= '0;
            idx         <= '0;
            to_cnt      <= '0;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            out_data    <= '0;
            out_cmd     <= '0;
            out_last    <= 1'b0;
            err_cksum   <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done_prev   <= rx_done;
            err_cksum   <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
            case (state)
                S_HUNT: begin
                    cksum  <= '0;
                    to_cnt <= '0;
                    if (byte_stb && rx_data == SYNC_BYTE)
                        state <= S_CMD;
                end
                S_CMD, S_ADDR, S_LEN, S_DATA, S_CKSUM: begin
                    // A strobe in the timeout cycle wins: the byte is parsed.
                    if (byte_stb) begin
                        to_cnt <= '0;
                        case (state)
                            S_CMD: begin
                                cmd_q <= rx_data;
                                cksum <= rx_data;
                                state <= S_ADDR;
                            end
                            S_ADDR: begin
                                addr_q <= rx_data;
                                cksum  <= cksum + rx_data;
                                state  <= S_LEN;
                            end
                            S_LEN: begin
                                if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                                    err_len <= 1'b1;
                                    state   <= S_HUNT;
                                end else begin
                                    len_q <= rx_data[IDX_W-1:0];
                                    cksum <= cksum + rx_data;
                                    idx   <= '0;
                                    state <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                cksum <= cksum + rx_data;
                                idx   <= idx_inc;
                                if (idx_inc == len_q)
                                    state <= S_CKSUM;
                            end
                            S_CKSUM: begin
                                if (rx_data == cksum) begin
                                    // Present beat 0 right away.
                                    // The first out_valid is one cycle later.
                                    idx       <= '0;
                                    state     <= S_DRAIN;
                                    out_valid <= 1'b1;
                                    out_data  <= buf_mem[0];
                                    out_addr  <= addr_q;
                                    out_cmd   <= cmd_q;
                                    out_last  <= (len_q == IDX_W'(1));
                                end else begin
                                    err_cksum <= 1'b1;
                                    state     <= S_HUNT;
                                end
                            end
                            default: state <= S_HUNT;
                        endcase
                    end else if (to_cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        to_cnt      <= '0;
                        state       <= S_HUNT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    to_cnt <= '0;
                    // The receiver cannot be stalled, so bytes seen here are dropped.
                    if (byte_stb)
                        overrun <= 1'b1;
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= S_HUNT;
                        end else begin
                            idx      <= idx_inc;
                            out_data <= buf_mem[idx_inc[BUF_AW-1:0]];
                            out_addr <= addr_q + 8'(idx_inc);
                            out_last <= (idx_inc == len_q - 1'b1);
                        end
                    end
                end
                default: state <= S_HUNT;
            endcase
        end
    end
endmodule
